spi_slave_block: RTL and testbench
==================================

# spi_slave_block

SPI responder (slave) for the far end of the link driven by `spi_topblock`. It oversamples SCLK, CS_N and MOSI in the local `clk` domain, shifts received words MSB-first into `rx_data`, and drives MISO from a single-entry transmit buffer. It operates in SPI mode 0 (CPOL=0, CPHA=0) and supports back-to-back words within one CS_N assertion. It is the bench partner for master-side regression and the slave front end for peripheral blocks.

## Interface
- `SPI_DATA_WIDTH`, 8: word length in bits (≥2).
- `TX_IDLE`, 0: word shifted out when the TX buffer is empty at a word boundary.
- `clk` in 1: system clock. Must be ≥ 8× SCLK frequency.
- `reset` in 1: asynchronous, active-low reset.
- `sclk` in 1: SPI clock from master. Asynchronous to `clk`.
- `cs_n` in 1: chip select from master, active-low. Asynchronous.
- `mosi` in 1: master-out data. Asynchronous.
- `miso` out 1: slave-out data. Driven 0 while not selected; no tristate in this block.
- `tx_data` in SPI_DATA_WIDTH: next word to transmit.
- `tx_valid` in 1: `tx_data` is offered. Accepted when `tx_valid && tx_ready`.
- `tx_ready` out 1: TX buffer empty.
- `rx_data` out SPI_DATA_WIDTH: last complete received word. Held until the next word completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: block is in ACTIVE.
- `frame_err` out 1: one-cycle pulse when CS_N deasserts mid-word.
- `tx_underrun` out 1: one-cycle pulse when `TX_IDLE` is loaded because the buffer was empty.

## Operation
- **Synchronizers.** `sclk`, `cs_n` and `mosi` each pass through a 2-flop synchronizer. A third flop on `sclk` and `cs_n` provides edge detection. All logic uses the synchronized versions. Synchronizer reset values: sclk 0, cs_n 1, mosi 0.
- **States.**
  - IDLE (`cs_n` high).
  - ACTIVE (`cs_n` low).
  - IDLE → ACTIVE on a synchronized cs_n falling edge.
  - ACTIVE → IDLE on a synchronized cs_n rising edge, from any bit position.
- **Word load.** On entry to ACTIVE, the TX shift register loads from the buffer if it is full; the buffer then empties and `tx_ready` rises. If the buffer is empty, the shift register loads `TX_IDLE` and `tx_underrun` pulses. `miso` presents the shift MSB from the same cycle.
- **Synchronized sclk rising edge.**
  - Shift sync'd mosi into the RX shift LSB.
  - Increment the bit counter (width clog2(SPI_DATA_WIDTH)).
  - On the SPI_DATA_WIDTH-th bit: write the assembled word to `rx_data`, pulse `rx_valid`, and wrap the counter to 0.
- **Synchronized sclk falling edge.**
  - If the counter is 0 (word boundary), reload the TX shift register by the word-load rule.
  - Otherwise, shift the TX register left by one.
- **Frame abort.** CS_N rising with counter ≠ 0 discards the partial RX word (no `rx_valid`), pulses `frame_err`, and resets the counter. CS_N rising with counter = 0 is a clean end.
- **Buffer write.** Allowed in any state. `tx_ready` low blocks further writes. If a write and an empty-buffer word load happen in the same cycle:
  - the current word gets `TX_IDLE` and `tx_underrun` pulses;
  - the written word stays in the buffer for the next word.
- **No RX backpressure.** An unread `rx_data` is overwritten.
- **SCLK outside ACTIVE** is ignored.
- **Reset** mid-frame returns to IDLE immediately. Outputs are forced to their reset values and any buffered TX word is lost.

## Timing
- **Reset values:**
  - `miso` 0
  - `rx_data` 0
  - `rx_valid` 0
  - `tx_ready` 1
  - `busy` 0
  - `frame_err` 0
  - `tx_underrun` 0
- **Input-to-internal latency.** Pad edge to internal edge detect is 3 `clk` cycles (+1 for sampling uncertainty).
- **`rx_valid`** asserts 3–4 `clk` cycles after the pad-level SCLK rising edge of the last bit.
- **MISO after SCLK falling.** `miso` updates 3–4 `clk` cycles after the pad SCLK falling edge. A half-period of ≥4 `clk` cycles (SCLK ≤ clk/8) keeps MISO valid before the master's next rising edge.
- **First bit.** The first MISO bit is valid 3–4 cycles after the CS_N falling edge. The master must wait ≥4 `clk` cycles from CS_N low to the first SCLK rise.
- **`busy`** follows CS_N with the same 3-cycle latency.
- **Pulse width.** `rx_valid`, `frame_err` and `tx_underrun` are exactly 1 cycle each.

## Test plan
- **Reset:** hold `reset`=0 with toggling pins → all outputs at reset values, `tx_ready`=1. Release reset → no pulses.
- **Single word:** load `tx_data`=0xA5, master sends 0x3C in one frame → `rx_data`=0x3C with one `rx_valid` pulse, master reads 0xA5, `tx_underrun` never pulses.
- **Burst:** preload 0x11, write 0x22 after `tx_ready` rises, master sends 0xF0, 0x0F under one CS_N → two `rx_valid` pulses (0xF0, 0x0F), master reads 0x11, 0x22.
- **Underrun:** empty buffer, `TX_IDLE`=0x00, master sends 0x81 → MISO shifts 0x00, `tx_underrun` pulses once at frame start, `rx_data`=0x81.
- **Abort:** CS_N deasserts after 5 SCLK cycles → `frame_err` pulses once, no `rx_valid`, `rx_data` unchanged. The next full frame with 0x5A → `rx_data`=0x5A.
- **Reset mid-frame:** assert `reset` after 3 bits → all outputs to reset values, and `busy` stays 0 until the next CS_N falling edge.

Source files
------------

// File: rtl/spi_slave_block.sv
// rtl/spi_slave_block.sv - SPI mode-0 responder with oversampled pins and single-entry TX buffer
module spi_slave_block #(
   parameter int                        SPI_DATA_WIDTH = 8,
   parameter logic [SPI_DATA_WIDTH-1:0] TX_IDLE        = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sclk,
   input  logic                      cs_n,
   input  logic                      mosi,
   output logic                      miso,
   input  logic [SPI_DATA_WIDTH-1:0] tx_data,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic [SPI_DATA_WIDTH-1:0] rx_data,
   output logic                      rx_valid,
   output logic                      busy,
   output logic                      frame_err,
   output logic                      tx_underrun
);
   localparam int CW = $clog2(SPI_DATA_WIDTH);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state, state_nxt;

   logic [2:0]                sclk_s, cs_s;
   logic [1:0]                mosi_s;
   logic [CW-1:0]             bit_cnt;
   logic [SPI_DATA_WIDTH-1:0] tx_sh, buf_data;
   logic [SPI_DATA_WIDTH-2:0] rx_sh;
   logic [SPI_DATA_WIDTH-1:0] rx_word;
   logic                      buf_full;
   logic                      sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic                      word_load, shift_tx, shift_rx, abort;

   // Index 1 is the synchronized level, index 2 the previous level for edge detect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_s <= 3'b000;
         cs_s   <= 3'b111;
         mosi_s <= 2'b00;
      end else begin
         sclk_s <= {sclk_s[1:0], sclk};
         cs_s   <= {cs_s[1:0], cs_n};
         mosi_s <= {mosi_s[0], mosi};
      end
   end

   assign sclk_rise = sclk_s[1] & ~sclk_s[2];
   assign sclk_fall = ~sclk_s[1] & sclk_s[2];
   assign cs_rise   = cs_s[1] & ~cs_s[2];
   assign cs_fall   = ~cs_s[1] & cs_s[2];
   assign rx_word   = {rx_sh, mosi_s[1]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // A CS_N rise wins over any SCLK edge seen in the same cycle.
   always_comb begin
      state_nxt = state;
      word_load = 1'b0;
      shift_tx  = 1'b0;
      shift_rx  = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_nxt = ACTIVE;
               word_load = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_nxt = IDLE;
               abort     = (bit_cnt != '0);
            end else begin
               shift_rx  = sclk_rise;
               word_load = sclk_fall && (bit_cnt == '0);
               shift_tx  = sclk_fall && (bit_cnt != '0);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_sh       <= '0;
         buf_data    <= '0;
         buf_full    <= 1'b0;
         rx_sh       <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         bit_cnt     <= '0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
         // Accept and drain are exclusive: accept needs an empty buffer, drain a full one.
         if (tx_valid && !buf_full) begin
            buf_data <= tx_data;
            buf_full <= 1'b1;
         end
         if (word_load) begin
            if (buf_full) begin
               tx_sh    <= buf_data;
               buf_full <= 1'b0;
            end else begin
               tx_sh       <= TX_IDLE;
               tx_underrun <= 1'b1;
            end
         end else if (shift_tx) begin
            tx_sh <= {tx_sh[SPI_DATA_WIDTH-2:0], 1'b0};
         end
         if (shift_rx) begin
            rx_sh <= rx_word[SPI_DATA_WIDTH-2:0];
            if (bit_cnt == CW'(SPI_DATA_WIDTH - 1)) begin
               rx_data  <= rx_word;
               rx_valid <= 1'b1;
               bit_cnt  <= '0;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
         if (abort) begin
            bit_cnt   <= '0;
            frame_err <= 1'b1;
         end
      end
   end

   assign tx_ready = ~buf_full;
   assign busy     = (state == ACTIVE);
   assign miso     = busy & tx_sh[SPI_DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_block.sv
// tb/tb_spi_slave_block.sv - scoreboard bench for spi_slave_block driven by a behavioural mode-0 master
module tb_spi_slave_block;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       frame_err;
   logic       tx_underrun;

   int n_checks = 0;
   int n_fail   = 0;
   int rx_cnt = 0, ferr_cnt = 0, und_cnt = 0;
   int ferr_exp = 0, und_exp = 0;
   logic [7:0] rx_exp[$];
   logic rv_prev = 1'b0, fe_prev = 1'b0, un_prev = 1'b0;

   spi_slave_block #(.SPI_DATA_WIDTH(8), .TX_IDLE(8'h00)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
      .frame_err(frame_err), .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: pops the expected word on each rx_valid and tracks pulse widths.
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         check("rx_valid_width", {31'd0, rv_prev}, 32'd0);
         if (rx_exp.size() == 0) check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
         else check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp.pop_front()});
      end
      if (frame_err) begin
         ferr_cnt++;
         check("frame_err_width", {31'd0, fe_prev}, 32'd0);
      end
      if (tx_underrun) begin
         und_cnt++;
         check("tx_underrun_width", {31'd0, un_prev}, 32'd0);
      end
      rv_prev = rx_valid;
      fe_prev = frame_err;
      un_prev = tx_underrun;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic tx_write(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      wait_cyc(1);
      tx_valid = 1'b0;
   endtask

   task automatic clock_bit(input logic b, input logic last, output logic m);
      mosi = b;
      wait_cyc(HALF);
      m    = miso;
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
      if (last) cs_n = 1'b1;
   endtask

   task automatic spi_frame(input logic [15:0] words, input int nbits, output logic [15:0] got);
      logic m;
      got  = '0;
      cs_n = 1'b0;
      wait_cyc(HALF);
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      check("underrun_at_start", und_cnt, und_exp);
      for (int i = 0; i < nbits; i++) begin
         clock_bit(words[15-i], i == nbits - 1, m);
         got = {got[14:0], m};
      end
      wait_cyc(12);
      check("busy_after_frame", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"}, {31'd0, miso}, 32'd0);
      check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
      check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
      check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
      check({tag, "_tx_underrun"}, {31'd0, tx_underrun}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got;
      logic [2:0]  part;
      logic        m;
      int          k;

      // Reset held with pins toggling
      for (int i = 0; i < 20; i++) begin
         cs_n = i[0];
         sclk = i[1];
         mosi = i[2];
         wait_cyc(1);
      end
      check_reset_outputs("rst_hold");
      cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      wait_cyc(3);
      reset = 1'b1;
      wait_cyc(10);
      check("rst_release_pulses", rx_cnt + ferr_cnt + und_cnt, 0);
      check("rst_release_busy", {31'd0, busy}, 32'd0);

      // Single word: buffer 0xA5, master sends 0x3C
      tx_write(8'hA5);
      check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
      rx_exp.push_back(8'h3C);
      spi_frame({8'h3C, 8'h00}, 8, got);
      check("single_miso", {24'd0, got[7:0]}, 32'hA5);
      check("single_rx_hold", {24'd0, rx_data}, 32'h3C);
      check("single_underrun", und_cnt, und_exp);
      check("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);

      // Burst: two words under one CS_N, second word written once the buffer frees
      tx_write(8'h11);
      rx_exp.push_back(8'hF0);
      rx_exp.push_back(8'h0F);
      fork
         spi_frame({8'hF0, 8'h0F}, 16, got);
         begin
            k = 0;
            while (!tx_ready && k < 100) begin
               wait_cyc(1);
               k++;
            end
            check("burst_tx_ready_rise", {31'd0, tx_ready}, 32'd1);
            tx_write(8'h22);
         end
      join
      check("burst_miso", {16'd0, got}, 32'h1122);
      check("burst_rx_count", rx_cnt, 3);
      check("burst_underrun", und_cnt, und_exp);

      // Underrun: empty buffer shifts TX_IDLE
      und_exp++;
      rx_exp.push_back(8'h81);
      spi_frame({8'h81, 8'h00}, 8, got);
      check("underrun_miso", {24'd0, got[7:0]}, 32'h00);
      check("underrun_count", und_cnt, und_exp);
      check("underrun_rx", {24'd0, rx_data}, 32'h81);

      // Abort after 5 bits, then a clean frame
      und_exp++;
      ferr_exp++;
      spi_frame({8'hC3, 8'h00}, 5, got);
      check("abort_frame_err", ferr_cnt, ferr_exp);
      check("abort_rx_count", rx_cnt, 4);
      check("abort_rx_unchanged", {24'd0, rx_data}, 32'h81);
      und_exp++;
      rx_exp.push_back(8'h5A);
      spi_frame({8'h5A, 8'h00}, 8, got);
      check("post_abort_rx", {24'd0, rx_data}, 32'h5A);
      check("post_abort_frame_err", ferr_cnt, ferr_exp);

      // Reset after 3 bits with a word still buffered
      tx_write(8'h33);
      cs_n = 1'b0;
      wait_cyc(HALF);
      check("rmid_underrun_start", und_cnt, und_exp);
      tx_write(8'h44);
      wait_cyc(2);
      check("rmid_buffer_full", {31'd0, tx_ready}, 32'd0);
      part = '0;
      for (int i = 0; i < 3; i++) begin
         clock_bit(1'b1, 1'b0, m);
         part = {part[1:0], m};
      end
      check("rmid_miso_bits", {29'd0, part}, 32'd1);
      wait_cyc(2);
      reset = 1'b0;
      wait_cyc(2);
      check_reset_outputs("rmid");
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_cyc(2);
      reset = 1'b1;
      wait_cyc(20);
      check("rmid_busy_stays_low", {31'd0, busy}, 32'd0);
      check("rmid_no_pulses", rx_cnt + ferr_cnt, 5 + ferr_exp);
      und_exp++;
      rx_exp.push_back(8'hE7);
      spi_frame({8'hE7, 8'h00}, 8, got);
      check("rmid_buffer_lost", {24'd0, got[7:0]}, 32'h00);
      check("rmid_next_rx", {24'd0, rx_data}, 32'hE7);

      check("final_rx_queue_empty", rx_exp.size(), 0);
      check("final_frame_err", ferr_cnt, ferr_exp);
      check("final_underrun", und_cnt, und_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
